digit_serial_addsub: RTL and testbench

Multi-cycle adder/subtractor that resolves a WIDTH-bit operation one 4-bit digit per clock, LSB digit first. Each digit uses 4-bit carry-lookahead, and a registered carry links one digit to the next. The block sits in the adder library as the area-lean alternative to the fully parallel lookahead adders. Operands arrive on a valid/ready input channel and results leave on a valid/ready output channel.

---
 rtl/addsub_pkg.sv | 16 +
 rtl/digit_serial_addsub_cla_slice_4bit.sv | 29 ++
 rtl/digit_serial_addsub.sv | 120 ++++++++++++
 tb/tb_digit_serial_addsub.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int num_digits(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/digit_serial_addsub_cla_slice_4bit.sv
// One 4-bit carry-lookahead digit: sums plus the carry out of every bit position.
module cla_slice_4bit
  import addsub_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic [DIGIT_W-1:0] c
);

  logic [DIGIT_W-1:0] w_p;
  logic [DIGIT_W-1:0] w_g;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is a flat two-level term of p/g/cin, so no carry ripples inside the digit.
  assign c[0] = w_g[0] | (w_p[0] & cin);
  assign c[1] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign c[2] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign c[3] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s = w_p ^ {c[2:0], cin};

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: one 4-bit lookahead digit per clock, LSB digit first.
// Define DIGIT_SERIAL_ADDSUB_OVF_EN to build the signed-overflow output (otherwise ovf=0).
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N = num_digits(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [IDX_W-1:0]   r_idx;
  logic [DIGIT_W-1:0] w_a_d;
  logic [DIGIT_W-1:0] w_b_d;
  logic [DIGIT_W-1:0] w_s;
  logic [DIGIT_W-1:0] w_c;
  logic               w_accept;
  logic               w_last;
  logic               w_unused_c;

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_idx == LAST_IDX);

  assign w_a_d = r_a[int'(r_idx) * DIGIT_W +: DIGIT_W];
  assign w_b_d = r_b[int'(r_idx) * DIGIT_W +: DIGIT_W];

  cla_slice_4bit u_slice (
    .a  (w_a_d),
    .b  (w_b_d),
    .cin(r_carry),
    .s  (w_s),
    .c  (w_c)
  );

  assign w_unused_c = ^w_c[2:0];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b ^ {WIDTH{sub}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_carry <= sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[int'(r_idx) * DIGIT_W +: DIGIT_W] <= w_s;
      r_carry <= w_c[DIGIT_W-1];
      r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
      if (w_last) r_cout <= w_c[DIGIT_W-1];
    end
  end

`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
  logic r_ovf;

  // Overflow is the carry into the MSB disagreeing with the carry out of it.
  always_ff @(posedge clk) begin
    if (rst)                            r_ovf <= 1'b0;
    else if ((r_state == RUN) && w_last) r_ovf <= w_c[DIGIT_W-2] ^ w_c[DIGIT_W-1];
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench driving a WIDTH=8 and a WIDTH=32 instance of digit_serial_addsub.
module tb_digit_serial_addsub;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv8 = 1'b0, ir8, sub8 = 1'b0, ov8, or8 = 1'b0, co8, of8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        iv32 = 1'b0, ir32, sub32 = 1'b0, ov32, or32 = 1'b0, co32, of32;
  logic [31:0] a32 = '0, b32 = '0, sum32;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q8[$];
  exp_t q32[$];
  exp_t last_e;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(co8), .ovf(of8)
  );

  digit_serial_addsub #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sub(sub32),
    .out_valid(ov32), .out_ready(or32), .sum(sum32), .cout(co32), .ovf(of32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide integer add of a, (optionally inverted) b and sub.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub);
    exp_t        m;
    logic [32:0] mask;
    logic [32:0] full;
    logic [31:0] bb;
    mask   = (33'd1 << w) - 33'd1;
    bb     = (sub ? ~b : b) & mask[31:0];
    full   = {1'b0, a & mask[31:0]} + {1'b0, bb} + 33'(sub);
    m.sum  = full[31:0] & mask[31:0];
    m.cout = full[w];
`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
    m.ovf  = (a[w-1] == bb[w-1]) && (m.sum[w-1] != a[w-1]);
`else
    m.ovf  = 1'b0;
`endif
    return m;
  endfunction

  task automatic start(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sub);
    @(negedge clk);
    if (w == 8) begin
      check("in_ready8_idle", 32'(ir8), 32'd1);
      iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sub8 = sub;
      q8.push_back(model(8, a, b, sub));
    end else begin
      check("in_ready32_idle", 32'(ir32), 32'd1);
      iv32 = 1'b1; a32 = a; b32 = b; sub32 = sub;
      q32.push_back(model(32, a, b, sub));
    end
    @(posedge clk);
    #1;
    iv8  = 1'b0;
    iv32 = 1'b0;
  endtask

  task automatic wait_result(input int w, input int exp_lat);
    int   cnt;
    logic v;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      v = (w == 8) ? ov8 : ov32;
      if (v || cnt >= 200) break;
      cnt++;
    end
    check($sformatf("latency%0d", w), 32'(cnt), 32'(exp_lat));
    if (w == 8) begin
      e = q8.pop_front();
      check("sum8", {24'd0, sum8}, e.sum);
      check("cout8", 32'(co8), 32'(e.cout));
      check("ovf8", 32'(of8), 32'(e.ovf));
      check("in_ready8_busy", 32'(ir8), 32'd0);
    end else begin
      e = q32.pop_front();
      check("sum32", sum32, e.sum);
      check("cout32", 32'(co32), 32'(e.cout));
      check("ovf32", 32'(of32), 32'(e.ovf));
      check("in_ready32_busy", 32'(ir32), 32'd0);
    end
    last_e = e;
  endtask

  task automatic release_result(input int w);
    if (w == 8) or8 = 1'b1; else or32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8  = 1'b0;
    or32 = 1'b0;
    if (w == 8) begin
      check("out_valid8_after_xfer", 32'(ov8), 32'd0);
      check("in_ready8_after_xfer", 32'(ir8), 32'd1);
    end else begin
      check("out_valid32_after_xfer", 32'(ov32), 32'd0);
      check("in_ready32_after_xfer", 32'(ir32), 32'd1);
    end
  endtask

  task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic sub);
    start(w, a, b, sub);
    wait_result(w, w / 4);
    release_result(w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid8", 32'(ov8), 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    check("rst_cout8", 32'(co8), 32'd0);
    check("rst_ovf8", 32'(of8), 32'd0);
    check("rst_in_ready8", 32'(ir8), 32'd0);
    check("rst_out_valid32", 32'(ov32), 32'd0);
    check("rst_in_ready32", 32'(ir32), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready8_post_rst", 32'(ir8), 32'd1);

    op(8, 32'h3C, 32'h14, 1'b0);
    op(8, 32'h10, 32'h20, 1'b1);
    op(8, 32'h20, 32'h10, 1'b1);
    op(8, 32'h7F, 32'h01, 1'b0);
    op(8, 32'hFF, 32'h01, 1'b0);
    op(8, 32'h80, 32'h01, 1'b1);

    // Backpressure: result must hold while new operands are offered and ignored.
    start(8, 32'h55, 32'h2A, 1'b0);
    wait_result(8, 2);
    for (int i = 0; i < 5; i++) begin
      iv8  = i[0];
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      sub8 = ~sub8;
      @(negedge clk);
      check("bp_sum8", {24'd0, sum8}, last_e.sum);
      check("bp_cout8", 32'(co8), 32'(last_e.cout));
      check("bp_ovf8", 32'(of8), 32'(last_e.ovf));
      check("bp_out_valid8", 32'(ov8), 32'd1);
      check("bp_in_ready8", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0;
    release_result(8);
    repeat (4) @(negedge clk);
    check("bp_no_extra_result8", 32'(ov8), 32'd0);

    // Abort a 32-bit operation mid-RUN.
    start(32, 32'h12345678, 32'h11111111, 1'b0);
    void'(q32.pop_front());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready32_in_rst", 32'(ir32), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_out_valid32", 32'(ov32), 32'd0);
    check("abort_sum32", sum32, 32'd0);
    check("abort_cout32", 32'(co32), 32'd0);
    check("abort_in_ready32", 32'(ir32), 32'd1);
    repeat (10) @(negedge clk);
    check("abort_no_result32", 32'(ov32), 32'd0);

    op(32, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    op(32, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    op(32, 32'h00000000, 32'h00000001, 1'b1);
    for (int i = 0; i < 4; i++) op(32, $urandom, $urandom, 1'($urandom));
    for (int i = 0; i < 4; i++) op(8, $urandom, $urandom, 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
